// File: rtl/reg_file_pkg.sv
// Shared constants, types and helpers for the scoreboarded register file.
// Optional build macro used by reg_file_sb: REG_FILE_BYPASS_EN.
package reg_file_pkg;

    // Architectural register that is hardwired to zero.
    localparam int unsigned REG_ZERO_ADDR = 0;

    // Default width of one pending-write counter.
    localparam int unsigned PEND_W_DEF = 2;

    // Widest set of decrement sources (write ports + cancel) popcount handles.
    localparam int unsigned MAX_DEC_SRC = 16;

    // Pending-write counter at the default width.
    typedef logic [PEND_W_DEF-1:0] pend_cnt_t;

    // Number of set bits: turns per-register hit flags into a decrement amount.
    function automatic logic [4:0] popcount(input logic [MAX_DEC_SRC-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_DEC_SRC; i++) begin
            n = n + {4'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter for one register.
// Each cycle: next = cnt + inc - dec. A result below zero clamps to 0 and
// raises underflow_o for that cycle; a result above the maximum clamps there.
module sb_counter #(
    parameter int unsigned PEND_W = 2,
    parameter int unsigned DEC_W  = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              inc_i,
    input  logic [DEC_W-1:0]  dec_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              sat_o,
    output logic              underflow_o
);

    localparam int unsigned SUM_W = ((PEND_W > DEC_W) ? PEND_W : DEC_W) + 1;
    localparam logic [SUM_W-1:0] MAX_V = SUM_W'((1 << PEND_W) - 1);

    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0]  up, down;

    // Net the increment and decrement in one step, clamping at both ends.
    always_comb begin
        up          = SUM_W'(cnt_q) + SUM_W'(inc_i);
        down        = SUM_W'(dec_i);
        underflow_o = 1'b0;
        cnt_d       = cnt_q;
        if (down > up) begin
            cnt_d       = '0;
            underflow_o = 1'b1;
        end else if ((up - down) > MAX_V) begin
            cnt_d = PEND_W'(MAX_V);
        end else begin
            cnt_d = PEND_W'(up - down);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == '1);

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Register 0 reads as zero, is never busy and never counts retirements.
// Build macro: REG_FILE_BYPASS_EN enables write-through bypass on the read
// ports (same-cycle write data and post-retire busy are visible combinationally).
//
// Issue handshake: issue_valid_i / issue_ready_o. An issue takes effect only in
// a cycle where both are high. issue_ready_o is a function of current counter
// state and same-cycle retires only, never of issue_valid_i; an issue presented
// while ready is low is dropped and flags sb_err_o.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter  int unsigned XLEN         = 32,
    parameter  int unsigned NUM_REGS     = 32,
    parameter  int unsigned NUM_RD_PORTS = 2,
    parameter  int unsigned NUM_WR_PORTS = 1,
    parameter  int unsigned PEND_W       = PEND_W_DEF,
    localparam int unsigned AW           = $clog2(NUM_REGS)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_RD_PORTS*AW-1:0]     rd_addr_i,
    output logic [NUM_RD_PORTS*XLEN-1:0]   rd_data_o,
    output logic [NUM_RD_PORTS-1:0]        rd_busy_o,
    input  logic [NUM_WR_PORTS-1:0]        we_i,
    input  logic [NUM_WR_PORTS*AW-1:0]     wa_i,
    input  logic [NUM_WR_PORTS*XLEN-1:0]   wd_i,
    input  logic                           issue_valid_i,
    input  logic [AW-1:0]                  issue_rd_i,
    output logic                           issue_ready_o,
    input  logic                           cancel_valid_i,
    input  logic [AW-1:0]                  cancel_rd_i,
    output logic                           sb_err_o
);

    // Enough bits to count every write port plus the cancel port at once.
    localparam int unsigned DEC_W = $clog2(NUM_WR_PORTS + 2);
    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO_ADDR);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic                err_q, err_d;
    logic [PEND_W-1:0]   cnt    [NUM_REGS];
    logic [DEC_W-1:0]    dec    [NUM_REGS];
    logic [NUM_REGS-1:0] sat;
    logic [NUM_REGS-1:0] underflow;
    logic                issue_fire;

    // Per-register decrement: retiring writes plus a cancel aimed at it.
    always_comb begin
        logic [MAX_DEC_SRC-1:0] hits;
        hits = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            hits = '0;
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                hits[w] = we_i[w] && (wa_i[w*AW +: AW] == AW'(r));
            end
            hits[NUM_WR_PORTS] = cancel_valid_i && (cancel_rd_i == AW'(r));
            dec[r] = (r == int'(REG_ZERO_ADDR)) ? '0 : DEC_W'(popcount(hits));
        end
    end

    // Accept an issue unless the target counter is full with nothing retiring.
    always_comb begin
        issue_ready_o = 1'b1;
        if (issue_rd_i != ZERO_A) begin
            issue_ready_o = !sat[issue_rd_i] || (dec[issue_rd_i] != '0);
        end
    end

    assign issue_fire = issue_valid_i && issue_ready_o;

    // One pending counter per non-zero register; register 0 is never pending.
    assign cnt[0]       = '0;
    assign sat[0]       = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(
            .PEND_W (PEND_W),
            .DEC_W  (DEC_W)
        ) u_cnt (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .inc_i       (issue_fire && (issue_rd_i == AW'(g))),
            .dec_i       (dec[g]),
            .cnt_o       (cnt[g]),
            .sat_o       (sat[g]),
            .underflow_o (underflow[g])
        );
    end

    // Next register contents: ascending port order lets the highest port win.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (we_i[w] && (wa_i[w*AW +: AW] != ZERO_A)) begin
                regs_d[wa_i[w*AW +: AW]] = wd_i[w*XLEN +: XLEN];
            end
        end
    end

    // Sticky error: any counter underflow or an issue dropped for lack of room.
    always_comb begin
        err_d = err_q || (|underflow) || (issue_valid_i && !issue_ready_o);
    end

    // Register array and error flag; reset clears all state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            err_q  <= err_d;
        end
    end

    assign sb_err_o = err_q;

    // Combinational read ports, optionally forwarding same-cycle writes.
    always_comb begin
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;
        rd_data_o = '0;
        rd_busy_o = '0;
        addr      = '0;
        data      = '0;
        busy      = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            addr = rd_addr_i[p*AW +: AW];
            data = (addr == ZERO_A) ? '0 : regs_q[addr];
`ifdef REG_FILE_BYPASS_EN
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (we_i[w] && (wa_i[w*AW +: AW] != ZERO_A) &&
                    (wa_i[w*AW +: AW] == addr)) begin
                    data = wd_i[w*XLEN +: XLEN];
                end
            end
            busy = (addr != ZERO_A) && (32'(cnt[addr]) > 32'(dec[addr]));
`else
            busy = (addr != ZERO_A) && (cnt[addr] != '0);
`endif
            rd_data_o[p*XLEN +: XLEN] = data;
            rd_busy_o[p]              = busy;
        end
    end

endmodule
